act_tile_feeder: RTL and testbench
==================================

# act_tile_feeder

Upstream feeder for the systolic delay-line skew stage. It accepts one activation tile of LANES×TILE_K elements as a serial valid/ready stream and buffers it. On a `go` from the array controller it replays the tile column by column, all LANES lanes in parallel, one column per cycle. It then drives LANES-1 zero cycles so the per-lane delay lines behind it drain before the next tile.

## Interface
- WIDTH, 16, element width in bits
- LANES, 4, parallel output lanes (array rows), ≥1
- TILE_K, 8, elements per lane per tile, ≥1

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input element valid
- in_ready  out  1  feeder can accept an element
- in_data  in  WIDTH  input element, lane-major order: lane0 e0..e(K-1), lane1 e0.., …
- tile_ready  out  1  full tile buffered, waiting for go
- go  in  1  start streaming; honoured only while tile_ready=1
- abort  in  1  synchronous abort, highest priority after reset
- lane_data  out  LANES*WIDTH  lane l at bits [l*WIDTH +: WIDTH], registered
- lane_valid  out  1  lane_data carries tile column, registered
- done  out  1  one-cycle pulse, tile fully streamed and flushed

## Operation
- Storage: LANES×TILE_K×WIDTH buffer. Write pointer wp counts 0..LANES*TILE_K-1. Element at wp lands in lane wp/TILE_K, column wp%TILE_K. Buffer contents are not reset.
- States: LOAD, HOLD, STREAM, FLUSH.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready edge writes in_data and increments wp.
  - The write at wp=LANES*TILE_K-1 clears wp and moves to HOLD.
- HOLD:
  - in_ready=0, tile_ready=1.
  - go=1 moves to STREAM and loads column 0 into the output registers on that same edge.
  - A go that arrives in LOAD, including the same cycle as the final write, is ignored. It is not stored.
- STREAM:
  - Column counter k runs 0..TILE_K-1.
  - Each edge loads column k+1 into the output registers, with lane_valid=1.
  - After column TILE_K-1 has been output, go to FLUSH if LANES>1, else straight to LOAD with done.
- FLUSH:
  - lane_data=0, lane_valid=0 for LANES-1 cycles, counted by a flush counter.
  - Then return to LOAD, with done=1 for exactly the first cycle back in LOAD.
- Outside STREAM output cycles, lane_data is all zeros and lane_valid=0, so downstream delay lines always shift zeros.
- abort=1 at an edge, in any state:
  - next state LOAD, with wp, k and the flush counter cleared;
  - lane_data=0, lane_valid=0, done=0 from the next cycle;
  - partial or buffered tile discarded;
  - an input handshake in the abort cycle is dropped.
- Counter widths: $clog2 of their range, minimum 1 bit. No wrap-around beyond the stated terminal values.

## Timing
- Reset (rst_n=0, asynchronous): state LOAD, wp=k=0. Outputs:
  - in_ready=1
  - tile_ready=0
  - lane_data=0
  - lane_valid=0
  - done=0
- Load takes exactly LANES*TILE_K accepted handshakes. tile_ready rises the cycle after the final accepted handshake.
- go sampled high in HOLD at edge t:
  - lane_valid=1 with column 0 during cycle t+1;
  - column j during cycle t+1+j, through column TILE_K-1 at cycle t+TILE_K;
  - tile_ready=0 from cycle t+1.
- Zero/flush cycles t+TILE_K+1 .. t+TILE_K+LANES-1.
- done=1 and in_ready=1 in cycle t+TILE_K+LANES. The next tile's first handshake can complete at the end of that cycle.
- Total occupancy per tile: LANES*TILE_K load cycles (at full in_valid) + 1 HOLD minimum + TILE_K + LANES-1.
- Reset asserted mid-STREAM forces outputs to zero immediately, with no partial column held.

## Test plan
- Reset then idle, defaults: outputs in_ready=1, lane_valid=0, lane_data=0, done=0, tile_ready=0.
- Load values 1..32 continuously, then go one cycle later:
  - cycle after go: lane_data={25,17,9,1} (lane3..lane0);
  - next cycles {26,18,10,2} .. {32,24,16,8};
  - then 3 zero cycles, then done pulse.
- Load with in_valid toggling every other cycle:
  - exactly 32 elements accepted; tile_ready rises one cycle after the 32nd;
  - go held high throughout loading is ignored until HOLD, and streaming starts the cycle after HOLD is entered.
- abort during STREAM after column 3: lane_valid=0 and zeros next cycle, no done pulse, in_ready=1; a fresh 32-element tile then streams correctly.
- Asynchronous reset mid-FLUSH:
  - outputs zero without a clock edge;
  - after release, tile load and stream with LANES=1, TILE_K=1 gives one lane_valid cycle and done the next cycle.
- Back-to-back tiles: second tile's first element is accepted in the done cycle, and the second stream's columns match the second tile's contents.

Source files
------------

// File: rtl/act_tile_feeder.sv
// rtl/act_tile_feeder.sv - activation tile buffer and column replayer for the skew stage
module act_tile_feeder #(
    parameter int WIDTH  = 16,
    parameter int LANES  = 4,
    parameter int TILE_K = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     tile_ready,
    input  logic                     go,
    input  logic                     abort,
    output logic [LANES*WIDTH-1:0]   lane_data,
    output logic                     lane_valid,
    output logic                     done
);
    localparam int DEPTH = LANES * TILE_K;
    localparam int WPW   = (DEPTH > 1)  ? $clog2(DEPTH)     : 1;
    localparam int KW    = (TILE_K > 1) ? $clog2(TILE_K)    : 1;
    localparam int LW    = (LANES > 1)  ? $clog2(LANES)     : 1;
    localparam int FW    = (LANES > 2)  ? $clog2(LANES - 1) : 1;

    localparam logic [WPW-1:0] WP_LAST = WPW'(DEPTH - 1);
    localparam logic [KW-1:0]  K_LAST  = KW'(TILE_K - 1);
    localparam logic [FW-1:0]  F_LAST  = (LANES > 1) ? FW'(LANES - 2) : '0;

    typedef enum logic [1:0] {S_LOAD, S_HOLD, S_STREAM, S_FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [WPW-1:0]           wp_q, wp_d;
    logic [KW-1:0]            k_q, k_d;
    logic [FW-1:0]            fc_q, fc_d;
    logic [LANES*WIDTH-1:0]   lane_data_q, lane_data_d;
    logic                     lane_valid_q, lane_valid_d;
    logic                     done_q, done_d;

    logic [WIDTH-1:0]         mem_q [LANES][TILE_K];
    logic                     wr_en;
    logic [LW-1:0]            wr_lane;
    logic [KW-1:0]            wr_col;
    logic [KW-1:0]            rd_col;
    logic [LANES*WIDTH-1:0]   col_data;

    assign wr_lane = LW'(int'(wp_q) / TILE_K);
    assign wr_col  = KW'(int'(wp_q) % TILE_K);

    // Column presented on the next edge: 0 when launching from HOLD, k+1 while streaming.
    assign rd_col = (state_q == S_STREAM && k_q != K_LAST) ? k_q + 1'b1 : '0;

    for (genvar l = 0; l < LANES; l++) begin : g_col
        assign col_data[l*WIDTH +: WIDTH] = mem_q[l][rd_col];
    end

    // Tile storage; contents survive reset and abort, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_lane][wr_col] <= in_data;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            wp_q         <= '0;
            k_q          <= '0;
            fc_q         <= '0;
            lane_data_q  <= '0;
            lane_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            k_q          <= k_d;
            fc_q         <= fc_d;
            lane_data_q  <= lane_data_d;
            lane_valid_q <= lane_valid_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic; outputs default to zeros so the delay lines shift zeros when idle.
    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        k_d          = k_q;
        fc_d         = fc_q;
        lane_data_d  = '0;
        lane_valid_d = 1'b0;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wp_q == WP_LAST) begin
                        wp_d    = '0;
                        state_d = S_HOLD;
                    end else begin
                        wp_d = wp_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (go) begin
                    state_d      = S_STREAM;
                    k_d          = '0;
                    lane_data_d  = col_data;
                    lane_valid_d = 1'b1;
                end
            end
            S_STREAM: begin
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (LANES > 1) begin
                        state_d = S_FLUSH;
                        fc_d    = '0;
                    end else begin
                        state_d = S_LOAD;
                        done_d  = 1'b1;
                    end
                end else begin
                    k_d          = rd_col;
                    lane_data_d  = col_data;
                    lane_valid_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (fc_q == F_LAST) begin
                    fc_d    = '0;
                    state_d = S_LOAD;
                    done_d  = 1'b1;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase
        if (abort) begin
            state_d      = S_LOAD;
            wp_d         = '0;
            k_d          = '0;
            fc_d         = '0;
            lane_data_d  = '0;
            lane_valid_d = 1'b0;
            done_d       = 1'b0;
            wr_en        = 1'b0;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign tile_ready = (state_q == S_HOLD);
    assign lane_data  = lane_data_q;
    assign lane_valid = lane_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_act_tile_feeder.sv
// tb/tb_act_tile_feeder.sv - self-checking bench for act_tile_feeder
module tb_act_tile_feeder;
    localparam int WIDTH  = 16;
    localparam int LANES  = 4;
    localparam int TILE_K = 8;
    localparam int N      = LANES * TILE_K;
    localparam int DW     = LANES * WIDTH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic            tile_ready;
    logic            go = 1'b0;
    logic            abort = 1'b0;
    logic [DW-1:0]   lane_data;
    logic            lane_valid;
    logic            done;

    logic            s_in_valid = 1'b0;
    logic            s_in_ready;
    logic [WIDTH-1:0] s_in_data = '0;
    logic            s_tile_ready;
    logic            s_go = 1'b0;
    logic            s_abort = 1'b0;
    logic [WIDTH-1:0] s_lane_data;
    logic            s_lane_valid;
    logic            s_done;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    act_tile_feeder #(.WIDTH(WIDTH), .LANES(LANES), .TILE_K(TILE_K)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .tile_ready(tile_ready), .go(go), .abort(abort),
        .lane_data(lane_data), .lane_valid(lane_valid), .done(done)
    );

    act_tile_feeder #(.WIDTH(WIDTH), .LANES(1), .TILE_K(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .tile_ready(s_tile_ready), .go(s_go), .abort(s_abort),
        .lane_data(s_lane_data), .lane_valid(s_lane_valid), .done(s_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: a loaded-element count plus a queue of scheduled per-cycle output records.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          valid;
        logic          dn;
        logic          irdy;
        logic          trdy;
    } rec_t;

    rec_t             exp_cur;
    rec_t             sched [$];
    logic [WIDTH-1:0] tile [N];
    int               n_loaded;

    function automatic rec_t idle_rec();
        rec_t r;
        r = '0;
        r.irdy = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        rec_t r;
        if (!rst_n) begin
            n_loaded = 0;
            sched.delete();
            exp_cur = idle_rec();
        end else if (abort) begin
            n_loaded = 0;
            sched.delete();
            exp_cur = idle_rec();
        end else if (sched.size() > 0) begin
            exp_cur = sched.pop_front();
        end else if (n_loaded == N) begin
            if (go) begin
                for (int j = 0; j < TILE_K; j++) begin
                    r = '0;
                    r.valid = 1'b1;
                    for (int l = 0; l < LANES; l++) r.data[l*WIDTH +: WIDTH] = tile[l*TILE_K + j];
                    sched.push_back(r);
                end
                for (int f = 0; f < LANES - 1; f++) sched.push_back(rec_t'('0));
                r = idle_rec();
                r.dn = 1'b1;
                sched.push_back(r);
                n_loaded = 0;
                exp_cur = sched.pop_front();
            end else begin
                r = '0;
                r.trdy = 1'b1;
                exp_cur = r;
            end
        end else begin
            if (in_valid) begin
                tile[n_loaded] = in_data;
                n_loaded++;
            end
            if (n_loaded == N) begin
                r = '0;
                r.trdy = 1'b1;
                exp_cur = r;
            end else begin
                exp_cur = idle_rec();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_lane_data", 64'(lane_data), 64'(exp_cur.data));
            check("m_lane_valid", 64'(lane_valid), 64'(exp_cur.valid));
            check("m_done", 64'(done), 64'(exp_cur.dn));
            check("m_in_ready", 64'(in_ready), 64'(exp_cur.irdy));
            check("m_tile_ready", 64'(tile_ready), 64'(exp_cur.trdy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data = WIDTH'(d);
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("send_timeout", 64'd0, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_tile(input int base);
        for (int i = 0; i < N; i++) send(base + i);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!done && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("wait_done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        // Reset defaults
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_tile_ready", 64'(tile_ready), 64'd0);
        check("rst_lane_data", 64'(lane_data), 64'd0);
        check("rst_lane_valid", 64'(lane_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Continuous load of 1..32, go one cycle later
        load_tile(1);
        check("cont_tile_ready", 64'(tile_ready), 64'd1);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("cont_col0", 64'(lane_data), 64'h0019_0011_0009_0001);
        check("cont_col0_valid", 64'(lane_valid), 64'd1);
        check("cont_tile_ready_low", 64'(tile_ready), 64'd0);
        for (int j = 1; j < TILE_K; j++) begin
            tick();
            check("cont_col", 64'(lane_data),
                  {16'(25 + j), 16'(17 + j), 16'(9 + j), 16'(1 + j)});
        end
        for (int f = 0; f < LANES - 1; f++) begin
            tick();
            check("cont_flush_valid", 64'(lane_valid), 64'd0);
            check("cont_flush_done", 64'(done), 64'd0);
        end
        tick();
        check("cont_done", 64'(done), 64'd1);
        check("cont_done_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("cont_done_once", 64'(done), 64'd0);

        // Toggling in_valid with go held high throughout
        go = 1'b1;
        for (int i = 0; i < N; i++) begin
            send(64 + i);
            if (i != N - 1) tick();
        end
        check("tog_tile_ready", 64'(tile_ready), 64'd1);
        check("tog_not_early", 64'(lane_valid), 64'd0);
        tick();
        go = 1'b0;
        check("tog_col0", 64'(lane_data), 64'h0058_0050_0048_0040);
        check("tog_col0_valid", 64'(lane_valid), 64'd1);
        wait_done();
        tick();

        // Abort during stream after column 3
        load_tile(100);
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (3) tick();
        check("abort_col3", 64'(lane_data),
              {16'(100 + 24 + 3), 16'(100 + 16 + 3), 16'(100 + 8 + 3), 16'(100 + 3)});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 64'(lane_valid), 64'd0);
        check("abort_data", 64'(lane_data), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 12; i++) begin
            check("abort_no_done", 64'(done), 64'd0);
            tick();
        end
        load_tile(200);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("abort_fresh_col0", 64'(lane_data), 64'h00E0_00D8_00D0_00C8);
        wait_done();
        tick();

        // Asynchronous reset mid-stream
        load_tile(500);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        check("rs_valid_before", 64'(lane_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_async_valid", 64'(lane_valid), 64'd0);
        check("rs_async_data", 64'(lane_data), 64'd0);
        check("rs_async_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-flush
        load_tile(600);
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (TILE_K) tick();
        check("rf_in_flush", 64'(lane_valid), 64'd0);
        check("rf_in_ready_low", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rf_async_in_ready", 64'(in_ready), 64'd1);
        check("rf_async_data", 64'(lane_data), 64'd0);
        check("rf_async_done", 64'(done), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single-lane, single-column instance
        s_in_valid = 1'b1;
        s_in_data = 16'hABCD;
        check("s_in_ready", 64'(s_in_ready), 64'd1);
        tick();
        s_in_valid = 1'b0;
        check("s_tile_ready", 64'(s_tile_ready), 64'd1);
        s_go = 1'b1;
        tick();
        s_go = 1'b0;
        check("s_valid", 64'(s_lane_valid), 64'd1);
        check("s_data", 64'(s_lane_data), 64'hABCD);
        check("s_no_done_yet", 64'(s_done), 64'd0);
        tick();
        check("s_valid_end", 64'(s_lane_valid), 64'd0);
        check("s_done", 64'(s_done), 64'd1);
        check("s_done_in_ready", 64'(s_in_ready), 64'd1);
        tick();
        check("s_done_once", 64'(s_done), 64'd0);

        // Back-to-back tiles: next tile's first element accepted in the done cycle
        load_tile(300);
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_done();
        check("b2b_done_in_ready", 64'(in_ready), 64'd1);
        load_tile(400);
        check("b2b_tile_ready", 64'(tile_ready), 64'd1);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("b2b_col0", 64'(lane_data), 64'h01A8_01A0_0198_0190);
        tick();
        check("b2b_col1", 64'(lane_data), 64'h01A9_01A1_0199_0191);
        wait_done();
        repeat (3) tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
